user_out_arbiter: RTL and testbench
===================================

Name: user_out_arbiter

Overview:
- Round-robin arbiter that merges NUM_OUT_PORTS user-side output streams into the single user-to-interface stream of a leaf.
- Each user stream uses the ap_vld/ap_ack handshake. The merged stream tags each word with its source port index so leaf_interface can route it.
- Sits between the HLS operator outputs and leaf_interface inside the leaf, clocked by clk_user.
- A burst limit bounds how long one port can hold the grant.

Parameters:
- PAYLOAD_BITS, 32, width of one data word.
- NUM_OUT_PORTS, 4, number of user output streams (2..16).
- NUM_PORT_BITS, 4, width of the source-port tag; must satisfy 2^NUM_PORT_BITS >= NUM_OUT_PORTS.
- MAX_BURST, 8, maximum consecutive words accepted from one port per grant (1..255).

Ports:
- clk_user  input  1  user clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- din_leaf_user2arb  input  NUM_OUT_PORTS*PAYLOAD_BITS  concatenated user data; port i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user2arb  input  NUM_OUT_PORTS  per-port valid.
- ack_arb2user  output  NUM_OUT_PORTS  per-port acknowledge; a word transfers when vld and ack are both high in the same cycle.
- dout_arb2interface  output  NUM_PORT_BITS+PAYLOAD_BITS  registered word {port_tag, payload}.
- vld_arb2interface  output  1  output word valid.
- ack_interface2arb  input  1  interface acknowledge; the output word transfers when vld_arb2interface and ack_interface2arb are both high.
- grant_idx  output  NUM_PORT_BITS  current or most recent grant, for debug.

Behaviour:
- Reset (synchronous, active-high), applied on the next edge:
  - state=IDLE, ack_arb2user=0, vld_arb2interface=0, dout_arb2interface=0, grant_idx=0.
  - Burst counter=0, rr pointer=0 (port 0 has highest priority first).
- Reset mid-operation discards any buffered output word and any open grant. No user word is acked during a reset cycle.
- State IDLE:
  - If any vld_user2arb bit is high, select the first requesting port scanning upward from rr pointer with wrap-around.
  - Register that port in grant_idx, clear the burst counter, go to GRANT.
  - Arbitration costs one cycle; no acks are issued in IDLE.
- State GRANT:
  - ack_arb2user[grant_idx] = (output buffer empty) OR (output buffer draining this cycle). This is combinational from state and the buffer/interface ack.
  - All other ack bits are 0; at most one ack bit is ever high.
- Capture on a user transfer:
  - dout_arb2interface <= {grant_idx zero-extended, selected payload}, vld_arb2interface <= 1, burst counter +1.
- Output buffer:
  - One entry. vld_arb2interface falls after an interface transfer unless a new word is captured in the same cycle.
  - Simultaneous drain and capture is legal: sustained throughput is one word per cycle.
  - While vld_arb2interface=1 and ack_interface2arb=0, dout_arb2interface is held stable.
- Grant release, GRANT -> IDLE:
  - Occurs when the burst counter reaches MAX_BURST on a transfer, or when the granted port's vld is low in a GRANT cycle.
  - On release, rr pointer <= grant_idx+1, wrapping NUM_OUT_PORTS-1 -> 0.
  - Releasing on low vld costs no transfer; the next grant starts after the one-cycle IDLE.
- The output stream is never blocked by arbitration. A word buffered before release still drains in IDLE.
- Latency:
  - Request in cycle 0 (state IDLE) -> ack in cycle 1 -> vld_arb2interface in cycle 2.
  - Steady-state burst: 1 word per cycle. Rotation overhead: 1 idle cycle per grant.
- Ports with index >= NUM_OUT_PORTS do not exist; grant_idx never exceeds NUM_OUT_PORTS-1.
- A user port must hold its data stable while vld is high and ack is low (ap_hs rule). The arbiter samples data only on the transfer cycle.

Test Plan:
- Single port: port 2 sends 0x11,0x22,0x33 with ack_interface2arb=1 -> outputs {2,0x11},{2,0x22},{2,0x33} on consecutive cycles. First vld_arb2interface appears 2 cycles after port 2's first vld.
- Round-robin: ports 0,1,3 all continuously valid, MAX_BURST=2 -> tag sequence 0,0,1,1,3,3,0,0,... with one idle cycle between bursts.
- Backpressure: ack_interface2arb=0 for 5 cycles mid-burst -> dout_arb2interface held constant and exactly one user word acked. No words are lost or duplicated once ack returns (checked with counters per port).
- Early release: port 1 valid for 3 words then drops, port 0 valid -> grant moves to port 0 after one IDLE cycle. rr pointer=2 afterwards, so port 0 keeps priority only because it is the sole requester.
- Reset mid-burst: assert reset for 1 cycle while vld_arb2interface=1 -> next cycle all outputs are 0 and state is IDLE. Port 0 wins the next arbitration when all ports request.
- Random stress: all ports issue random vld and the interface acks with 50% probability for 10k cycles -> per-port output order matches input order and ack_arb2user is always one-hot or zero. No port waits more than (NUM_OUT_PORTS-1)*(MAX_BURST+1)+1 cycles for a grant.

Source files
------------

// File: rtl/user_out_arbiter_if.sv
// Handshake bundle between the user output streams, the round-robin arbiter and leaf_interface.
interface user_out_arbiter_if #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_OUT_PORTS = 4,
  parameter int unsigned NUM_PORT_BITS = 4
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2arb;
  logic [NUM_OUT_PORTS-1:0]               vld_user2arb;
  logic [NUM_OUT_PORTS-1:0]               ack_arb2user;
  logic [NUM_PORT_BITS+PAYLOAD_BITS-1:0]  dout_arb2interface;
  logic                                   vld_arb2interface;
  logic                                   ack_interface2arb;
  logic [NUM_PORT_BITS-1:0]               grant_idx;

  modport master (
    input  din_leaf_user2arb, vld_user2arb, ack_interface2arb,
    output ack_arb2user, dout_arb2interface, vld_arb2interface, grant_idx
  );

  modport slave (
    output din_leaf_user2arb, vld_user2arb, ack_interface2arb,
    input  ack_arb2user, dout_arb2interface, vld_arb2interface, grant_idx
  );
endinterface

// File: rtl/user_out_arbiter.sv
// Round-robin merge of NUM_OUT_PORTS ap_vld/ap_ack user streams into one tagged stream,
// with a burst limit per grant and a one-entry output buffer.
module user_out_arbiter #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_OUT_PORTS = 4,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned MAX_BURST     = 8
) (
  input  logic               clk_user,
  input  logic               reset,
  user_out_arbiter_if.master bus
);

  localparam int unsigned BURST_W = 8;
  localparam int unsigned OUT_W   = NUM_PORT_BITS + PAYLOAD_BITS;

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [NUM_PORT_BITS-1:0]   grant_q, grant_d;
  logic [NUM_PORT_BITS-1:0]   rr_q, rr_d;
  logic [BURST_W-1:0]         burst_q, burst_d;
  logic [OUT_W-1:0]           dout_q, dout_d;
  logic                       vld_q, vld_d;

  logic [NUM_OUT_PORTS-1:0]   ack_c;
  logic [NUM_PORT_BITS-1:0]   pick;
  logic [NUM_PORT_BITS-1:0]   grant_next;
  logic [PAYLOAD_BITS-1:0]    sel_data;
  logic                       found;
  logic                       any_req;
  logic                       grant_vld;
  logic                       xfer;
  logic                       burst_done;

  // Valid and payload of the currently granted port
  always_comb begin
    grant_vld = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_q == NUM_PORT_BITS'(i)) begin
        grant_vld = bus.vld_user2arb[i];
        sel_data  = bus.din_leaf_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // First requester scanning upward from the rr pointer, wrapping at NUM_OUT_PORTS
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_OUT_PORTS; off++) begin
      for (int unsigned j = 0; j < NUM_OUT_PORTS; j++) begin
        if (!found && bus.vld_user2arb[j] &&
            ((32'(rr_q) + off == j) || (32'(rr_q) + off == j + NUM_OUT_PORTS))) begin
          found = 1'b1;
          pick  = NUM_PORT_BITS'(j);
        end
      end
    end
  end

  assign any_req    = |bus.vld_user2arb;
  assign grant_next = (grant_q == NUM_PORT_BITS'(NUM_OUT_PORTS - 1)) ? '0
                                                                     : grant_q + NUM_PORT_BITS'(1);
  assign xfer       = |(ack_c & bus.vld_user2arb);
  assign burst_done = (burst_q + BURST_W'(1)) == BURST_W'(MAX_BURST);

  // State register
  always_ff @(posedge clk_user) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, grant bookkeeping and output buffer
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = pick;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (!grant_vld) begin
          state_d = IDLE;
          rr_d    = grant_next;
        end else if (xfer) begin
          burst_d = burst_q + BURST_W'(1);
          if (burst_done) begin
            state_d = IDLE;
            rr_d    = grant_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Capture wins over drain so a word can enter and leave in the same cycle
    if (xfer) begin
      dout_d = {grant_q, sel_data};
      vld_d  = 1'b1;
    end else if (bus.ack_interface2arb) begin
      vld_d  = 1'b0;
    end
  end

  // User acks: only the granted port, only when the buffer can take a word
  always_comb begin
    ack_c = '0;
    if (state_q == GRANT && !reset && (!vld_q || bus.ack_interface2arb)) begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        if (grant_q == NUM_PORT_BITS'(i)) ack_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.ack_arb2user       = ack_c;
  assign bus.dout_arb2interface = dout_q;
  assign bus.vld_arb2interface  = vld_q;
  assign bus.grant_idx          = grant_q;

endmodule

// File: tb/tb_user_out_arbiter.sv
// Directed and random checks of user_out_arbiter against a tagged-word scoreboard.
module tb_user_out_arbiter;

  localparam int unsigned PB    = 32;
  localparam int unsigned NP    = 4;
  localparam int unsigned NPB   = 4;
  localparam int unsigned MB    = 3;
  localparam int unsigned OW    = NPB + PB;
  localparam int          BOUND = (NP - 1) * (MB + 1) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  user_out_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_OUT_PORTS(NP), .NUM_PORT_BITS(NPB)) bus ();

  user_out_arbiter #(
    .PAYLOAD_BITS(PB), .NUM_OUT_PORTS(NP), .NUM_PORT_BITS(NPB), .MAX_BURST(MB)
  ) dut (
    .clk_user(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          remaining[NP];
  int          sent[NP];
  int          waitc[NP];
  logic [PB-1:0] base[NP];
  logic [PB-1:0] stepv[NP];
  bit          en[NP];
  bit          dir_en[NP];
  bit          rand_vld  = 1'b0;
  bit          ack_rand  = 1'b0;
  bit          fair_en   = 1'b0;
  logic        ack_fixed = 1'b1;

  logic [OW-1:0] sb[$];
  logic [OW-1:0] out_log[$];
  int            out_cyc[$];

  function automatic logic [PB-1:0] word_of(int i);
    return base[i] + PB'(sent[i]) * stepv[i];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [NP-1:0]    v;
    logic [NP*PB-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < NP; i++) begin
      if (rand_vld && !en[i]) en[i] = ($urandom_range(0, 1) == 1);
      v[i] = (remaining[i] > 0) && (rand_vld ? en[i] : dir_en[i]);
      d[i*PB +: PB] = word_of(i);
    end
    bus.vld_user2arb      = v;
    bus.din_leaf_user2arb = d;
    bus.ack_interface2arb = ack_rand ? 1'($urandom_range(0, 1)) : ack_fixed;
  endtask

  // One clock cycle: drive, sample mid-cycle, score transfers, then advance past the edge
  task automatic tick();
    logic [NP-1:0] a, v;
    logic          ov, ai;
    logic [OW-1:0] od, e;
    int            k;
    drive();
    #1;
    a  = bus.ack_arb2user;
    v  = bus.vld_user2arb;
    ov = bus.vld_arb2interface;
    ai = bus.ack_interface2arb;
    od = bus.dout_arb2interface;
    check("ack_onehot", 64'($countones(a) <= 1), 64'd1);
    if (reset) check("ack_in_reset", 64'(a), 64'd0);
    if (ov && ai) begin
      k = -1;
      for (int j = 0; j < sb.size(); j++) begin
        e = sb[j];
        if (k < 0 && e[OW-1 -: NPB] == od[OW-1 -: NPB]) k = j;
      end
      check("sb_present", 64'(k >= 0), 64'd1);
      if (k >= 0) begin
        check("sb_word", 64'(od), 64'(sb[k]));
        sb.delete(k);
      end
      out_log.push_back(od);
      out_cyc.push_back(cyc);
    end
    for (int i = 0; i < NP; i++) begin
      if (v[i] && a[i]) begin
        if (fair_en) check("grant_wait", 64'(waitc[i] <= BOUND), 64'd1);
        sb.push_back({NPB'(i), word_of(i)});
        sent[i]++;
        remaining[i]--;
        en[i]    = 1'b0;
        waitc[i] = 0;
      end else if (v[i]) begin
        waitc[i]++;
      end else begin
        waitc[i] = 0;
      end
    end
    @(posedge clk);
    cyc++;
    if (reset) sb.delete();
    #1;
  endtask

  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},   64'(bus.ack_arb2user),       64'd0);
    check({pfx, "_vld"},   64'(bus.vld_arb2interface),  64'd0);
    check({pfx, "_dout"},  64'(bus.dout_arb2interface), 64'd0);
    check({pfx, "_grant"}, 64'(bus.grant_idx),          64'd0);
  endtask

  initial begin
    int            c0, s0, total;
    int            rr_tags[6];
    logic [OW-1:0] w;
    rr_tags = '{3, 0, 1, 3, 0, 1};
    for (int i = 0; i < NP; i++) begin
      remaining[i] = 0; sent[i] = 0; waitc[i] = 0;
      base[i] = PB'((i + 1) << 24); stepv[i] = 32'd1;
      en[i] = 1'b0; dir_en[i] = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Single port, three words back to back
    base[2] = 32'h11; stepv[2] = 32'h11; remaining[2] = 3;
    clear_log();
    c0 = cyc;
    for (int t = 0; t < 20 && out_log.size() < 3; t++) tick();
    check("t1_count", 64'(out_log.size()), 64'd3);
    for (int k = 0; k < out_log.size() && k < 3; k++) begin
      check("t1_word", 64'(out_log[k]), 64'({NPB'(2), PB'(32'h11 * (k + 1))}));
      check("t1_cycle", 64'(out_cyc[k] - c0), 64'(2 + k));
    end
    repeat (3) tick();

    // Round robin over ports 0,1,3; pointer sits at 3 after port 2's burst
    remaining[0] = 6; remaining[1] = 6; remaining[3] = 6;
    clear_log();
    for (int t = 0; t < 60 && out_log.size() < 18; t++) tick();
    check("t2_count", 64'(out_log.size()), 64'd18);
    for (int k = 0; k < out_log.size() && k < 18; k++) begin
      w = out_log[k];
      check("t2_tag", 64'(w[OW-1 -: NPB]), 64'(rr_tags[k/3]));
      if (k > 0) check("t2_gap", 64'(out_cyc[k] - out_cyc[k-1]), 64'((k % 3 == 0) ? 2 : 1));
    end
    repeat (3) tick();

    // Backpressure: interface stalls from the first grant cycle for five cycles
    clear_log();
    remaining[0] = 6;
    s0 = sent[0];
    ack_fixed = 1'b1;
    tick();
    ack_fixed = 1'b0;
    repeat (5) begin
      tick();
      check("t3_hold_vld",  64'(bus.vld_arb2interface),  64'd1);
      check("t3_hold_dout", 64'(bus.dout_arb2interface), 64'({NPB'(0), PB'(base[0] + PB'(s0))}));
    end
    check("t3_user_acks", 64'(sent[0] - s0), 64'd1);
    ack_fixed = 1'b1;
    for (int t = 0; t < 40 && out_log.size() < 6; t++) tick();
    check("t3_count", 64'(out_log.size()), 64'd6);
    repeat (3) tick();
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Early release: port 1 stops after two words, port 0 follows after one idle cycle
    clear_log();
    remaining[1] = 2; remaining[0] = 3;
    for (int t = 0; t < 40 && out_log.size() < 5; t++) tick();
    check("t4_count", 64'(out_log.size()), 64'd5);
    if (out_log.size() >= 3) begin
      w = out_log[0]; check("t4_tag0", 64'(w[OW-1 -: NPB]), 64'd1);
      w = out_log[1]; check("t4_tag1", 64'(w[OW-1 -: NPB]), 64'd1);
      w = out_log[2]; check("t4_tag2", 64'(w[OW-1 -: NPB]), 64'd0);
      check("t4_gap_burst",   64'(out_cyc[1] - out_cyc[0]), 64'd1);
      check("t4_gap_release", 64'(out_cyc[2] - out_cyc[1]), 64'd3);
    end
    check("t4_grant", 64'(bus.grant_idx), 64'd0);
    repeat (3) tick();

    // Reset while a word is buffered, then all ports request
    remaining[2] = 5;
    for (int t = 0; t < 10 && !bus.vld_arb2interface; t++) tick();
    check("t5_buffered", 64'(bus.vld_arb2interface), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("t5_rst");
    remaining[0] = 3; remaining[1] = 3; remaining[3] = 3;
    clear_log();
    for (int t = 0; t < 10 && out_log.size() < 1; t++) tick();
    check("t5_first_count", 64'(out_log.size()), 64'd1);
    if (out_log.size() >= 1) begin
      w = out_log[0];
      check("t5_first_tag", 64'(w[OW-1 -: NPB]), 64'd0);
    end
    for (int t = 0; t < 100 &&
         (remaining[0] + remaining[1] + remaining[2] + remaining[3] > 0 ||
          sb.size() > 0 || bus.vld_arb2interface); t++) tick();
    check("t5_drained", 64'(sb.size()), 64'd0);

    // Random stress: fairness with a free-running interface, then 50% interface backpressure
    clear_log();
    for (int i = 0; i < NP; i++) begin
      remaining[i] = 100000; waitc[i] = 0; en[i] = 1'b0;
    end
    rand_vld  = 1'b1;
    fair_en   = 1'b1;
    ack_fixed = 1'b1;
    repeat (3000) tick();
    for (int i = 0; i < NP; i++) check("t6_wait_open", 64'(waitc[i] <= BOUND), 64'd1);
    fair_en  = 1'b0;
    ack_rand = 1'b1;
    repeat (7000) tick();
    total = out_log.size();
    check("t6_progress", 64'(total > 4000), 64'd1);
    rand_vld = 1'b0;
    ack_rand = 1'b0;
    for (int i = 0; i < NP; i++) dir_en[i] = 1'b0;
    repeat (10) tick();
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    check("t6_out_idle", 64'(bus.vld_arb2interface), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
